// File: rtl/cpu_pkg.sv
// Shared constants and types for the D-stage hazard scoreboard.
package cpu_pkg;

  localparam int unsigned SB_AW = 5;
  localparam int unsigned SB_TW = 4;

  function automatic int unsigned tmax_of(input int unsigned tw);
    return (2 ** tw) - 1;
  endfunction

  // TMAX marks "never used / never produced"
  localparam int unsigned TMAX = tmax_of(SB_TW);
  localparam int unsigned TMIN = 0;

  localparam int unsigned STG_E = 1;
  localparam int unsigned STG_M = 2;
  localparam int unsigned STG_W = 3;

  typedef struct packed {
    logic [SB_AW-1:0] wa;
    logic [SB_TW-1:0] tnew;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority encoder for one source register against the scoreboard.
module hazard_match
  import cpu_pkg::*;
#(
  parameter int unsigned AW   = SB_AW,
  parameter int unsigned TW   = SB_TW,
  parameter int unsigned NSTG = STG_W,
  parameter int unsigned SW   = $clog2(NSTG + 1)
) (
  input  logic [NSTG*(AW+TW)-1:0] i_sb,
  input  logic [AW-1:0]           i_ra,
  input  logic [TW-1:0]           i_tuse,
  output logic                    o_stall,
  output logic [SW-1:0]           o_fwd_sel
);

  localparam int unsigned   EW     = AW + TW;
  localparam logic [TW-1:0] L_TMAX = (TW == SB_TW) ? TW'(TMAX) : TW'(tmax_of(TW));

  logic          w_hit;
  logic [SW-1:0] w_stg;
  logic [TW-1:0] w_tnew;

  always_comb begin
    w_hit  = 1'b0;
    w_stg  = '0;
    w_tnew = '0;
    // scan oldest to youngest so the youngest match overwrites older ones
    for (int unsigned i = 0; i < NSTG; i++) begin
      if (i_ra != '0 && i_sb[(NSTG-1-i)*EW+TW +: AW] == i_ra) begin
        w_hit  = 1'b1;
        w_stg  = SW'(NSTG - i);
        w_tnew = i_sb[(NSTG-1-i)*EW +: TW];
      end
    end
  end

  assign o_stall   = w_hit && (i_tuse != L_TMAX) && (w_tnew > i_tuse);
  assign o_fwd_sel = (w_hit && w_tnew == TW'(TMIN)) ? w_stg : '0;

endmodule

// File: rtl/hazard_sb.sv
// Pipeline hazard scoreboard beside D: tracks {wa, tnew} per downstream stage,
// produces the F/D stall, D-stage forward selects and a saturating stall counter.
module hazard_sb
  import cpu_pkg::*;
#(
  parameter int unsigned AW   = SB_AW,
  parameter int unsigned TW   = SB_TW,
  parameter int unsigned NSTG = STG_W,
  parameter int unsigned SW   = $clog2(NSTG + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_wa,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_is_md,
  input  logic          md_busy,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] fwd_rs_sel,
  output logic [SW-1:0] fwd_rt_sel,
  output logic [31:0]   stall_cnt
);

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [TW-1:0] tnew;
  } entry_t;

  entry_t [NSTG:1] r_sb;
  logic [31:0]     r_stall_cnt;
  logic            w_stall_rs;
  logic            w_stall_rt;
  logic            w_load;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
    return (x == TW'(TMIN)) ? x : x - TW'(1);
  endfunction

  hazard_match #(.AW(AW), .TW(TW), .NSTG(NSTG), .SW(SW)) u_match_rs (
    .i_sb      (r_sb),
    .i_ra      (d_rs),
    .i_tuse    (d_tuse_rs),
    .o_stall   (w_stall_rs),
    .o_fwd_sel (fwd_rs_sel)
  );

  hazard_match #(.AW(AW), .TW(TW), .NSTG(NSTG), .SW(SW)) u_match_rt (
    .i_sb      (r_sb),
    .i_ra      (d_rt),
    .i_tuse    (d_tuse_rt),
    .o_stall   (w_stall_rt),
    .o_fwd_sel (fwd_rt_sel)
  );

  assign stall  = d_valid & (w_stall_rs | w_stall_rt | (d_is_md & md_busy));
  assign w_load = d_valid & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_load) begin
        r_sb[STG_E].wa   <= d_wa;
        r_sb[STG_E].tnew <= sat_dec(d_tnew);
      end else begin
        r_sb[STG_E] <= '0;
      end
      for (int unsigned k = STG_M; k <= NSTG; k++) begin
        r_sb[k].wa   <= r_sb[k-1].wa;
        r_sb[k].tnew <= sat_dec(r_sb[k-1].tnew);
      end
      if (stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_sb.sv
// Bench for hazard_sb: directed vector table, randomized run against an
// issue-time reference model, and a counter saturation sequence.
module tb_hazard_sb;
  import cpu_pkg::*;

  localparam int unsigned AW   = 5;
  localparam int unsigned TW   = 4;
  localparam int unsigned NSTG = 3;
  localparam int unsigned SW   = 2;

  logic          clk;
  logic          reset;
  logic          d_valid;
  logic [AW-1:0] d_rs, d_rt, d_wa;
  logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic          d_is_md, md_busy, flush;
  logic          stall;
  logic [SW-1:0] fwd_rs_sel, fwd_rt_sel;
  logic [31:0]   stall_cnt;

  hazard_sb #(.AW(AW), .TW(TW), .NSTG(NSTG), .SW(SW)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_wa       (d_wa),
    .d_tnew     (d_tnew),
    .d_is_md    (d_is_md),
    .md_busy    (md_busy),
    .flush      (flush),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        rst, v;
    logic [4:0]  rs, rt;
    logic [3:0]  trs, trt;
    logic [4:0]  wa;
    logic [3:0]  tn;
    logic        md, bz, fl;
    logic        st;
    logic [1:0]  frs, frt;
    logic [31:0] cnt;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input logic rst, input logic v, input int rs, input int rt,
                              input int trs, input int trt, input int wa, input int tn,
                              input logic md, input logic bz, input logic fl,
                              input logic st, input int frs, input int frt, input int cnt);
    vec_t r;
    r.rst = rst; r.v = v;
    r.rs = 5'(rs); r.rt = 5'(rt); r.trs = 4'(trs); r.trt = 4'(trt);
    r.wa = 5'(wa); r.tn = 4'(tn);
    r.md = md; r.bz = bz; r.fl = fl;
    r.st = st; r.frs = 2'(frs); r.frt = 2'(frt); r.cnt = 32'(cnt);
    return r;
  endfunction

  task automatic drive(input logic rst, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [3:0] trs, input logic [3:0] trt, input logic [4:0] wa,
                       input logic [3:0] tn, input logic md, input logic bz, input logic fl);
    reset = rst; d_valid = v; d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
    d_wa = wa; d_tnew = tn; d_is_md = md; md_busy = bz; flush = fl;
  endtask

  // Reference model: each in-flight instruction is remembered by its issue
  // cycle; its stage and remaining Tnew follow from the elapsed cycles.
  typedef struct {
    logic [4:0] wa;
    int         issue;
    int         tnew;
  } inf_t;

  inf_t q[$];
  int   cyc;
  longint mcnt;

  function automatic void mref(input logic [4:0] r, input logic [3:0] tuse,
                               output logic st, output int fwd);
    int best = NSTG + 1;
    int rem  = 0;
    foreach (q[i]) begin
      int stage = cyc - q[i].issue;
      if (stage >= 1 && stage <= int'(NSTG) && r != 0 && q[i].wa == r && stage < best) begin
        best = stage;
        rem  = (q[i].tnew > stage) ? q[i].tnew - stage : 0;
      end
    end
    st  = d_valid && best <= int'(NSTG) && int'(tuse) != int'(TMAX) && rem > int'(tuse);
    fwd = (best <= int'(NSTG) && rem == 0) ? best : 0;
  endfunction

  initial begin
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 drive(1'b0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("reset_stall", 32'(stall), 0);
    chk("reset_fwd_rs", 32'(fwd_rs_sel), 0);
    chk("reset_fwd_rt", 32'(fwd_rt_sel), 0);
    chk("reset_cnt", stall_cnt, 0);

    //        rst v rs rt trs trt wa tn md bz fl | st frs frt cnt
    // lw $1 -> add $2,$1,$3
    tab.push_back(mk(0, 1, 0, 0, 15, 15, 1, 3, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 1, 3,  1,  1, 2, 2, 0, 0, 0, 1, 0, 0, 0));
    tab.push_back(mk(0, 1, 1, 3,  1,  1, 2, 2, 0, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(0, 0, 2, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(0, 0, 2, 0,  0,  0, 0, 0, 0, 0, 0, 0, 2, 0, 1));
    tab.push_back(mk(0, 0, 2, 2,  0,  0, 0, 0, 0, 0, 0, 0, 3, 3, 1));
    // lw $1 -> beq $1,$0
    tab.push_back(mk(0, 1, 0, 0, 15, 15, 1, 3, 0, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(0, 1, 1, 0,  0, 15, 0, 15, 0, 0, 0, 1, 0, 0, 1));
    tab.push_back(mk(0, 1, 1, 0,  0, 15, 0, 15, 0, 0, 0, 1, 0, 0, 2));
    tab.push_back(mk(0, 1, 1, 0,  0, 15, 0, 15, 0, 0, 0, 0, 3, 0, 3));
    tab.push_back(mk(0, 1, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tab.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tab.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    // ori $1 (M), add $1 (E), beq reads $1
    tab.push_back(mk(0, 1, 0, 0, 15, 15, 1, 2, 0, 0, 0, 0, 0, 0, 3));
    tab.push_back(mk(0, 1, 0, 0, 15, 15, 1, 2, 0, 0, 0, 0, 0, 0, 3));
    tab.push_back(mk(0, 1, 1, 0,  0, 15, 0, 0, 0, 0, 0, 1, 0, 0, 3));
    tab.push_back(mk(0, 1, 1, 0,  0, 15, 0, 0, 0, 0, 0, 0, 2, 0, 4));
    tab.push_back(mk(0, 0, 1, 1,  0,  0, 0, 0, 0, 0, 0, 0, 3, 3, 4));
    tab.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    // writer of $0 then reader of $0
    tab.push_back(mk(0, 1, 0, 0, 15, 15, 0, 3, 0, 0, 0, 0, 0, 0, 4));
    tab.push_back(mk(0, 1, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    tab.push_back(mk(0, 1, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    // same register on rs and rt, only rt's Tuse stalls
    tab.push_back(mk(0, 1, 0, 0, 15, 15, 2, 2, 0, 0, 0, 0, 0, 0, 4));
    tab.push_back(mk(0, 1, 2, 2, 15,  0, 0, 0, 0, 0, 0, 1, 0, 0, 4));
    tab.push_back(mk(0, 1, 2, 2, 15,  0, 0, 0, 0, 0, 0, 0, 2, 2, 5));
    tab.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
    tab.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
    // mult held by md_busy for 5 cycles; rt=$3 would expose an early load
    for (int i = 0; i < 5; i++)
      tab.push_back(mk(0, 1, 0, 3, 0, 15, 3, 2, 1, 1, 0, 1, 0, 0, 5 + i));
    tab.push_back(mk(0, 1, 0, 3,  0, 15, 3, 2, 1, 0, 0, 0, 0, 0, 10));
    tab.push_back(mk(0, 0, 3, 3,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 10));
    tab.push_back(mk(0, 0, 3, 0,  0,  0, 0, 0, 0, 0, 0, 0, 2, 0, 10));
    tab.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 10));
    // reset in the middle of a lw->beq stall
    tab.push_back(mk(0, 1, 0, 0, 15, 15, 1, 3, 0, 0, 0, 0, 0, 0, 10));
    tab.push_back(mk(0, 1, 1, 0,  0, 15, 0, 0, 0, 0, 0, 1, 0, 0, 10));
    tab.push_back(mk(1, 1, 1, 0,  0, 15, 0, 0, 0, 0, 0, 1, 0, 0, 11));
    tab.push_back(mk(0, 1, 1, 0,  0, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // flush alone drops D; stall+flush gives one bubble
    tab.push_back(mk(0, 1, 0, 0, 15, 15, 1, 2, 0, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 1, 0,  0, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 15, 15, 2, 3, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 2, 0,  0, 15, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(0, 1, 2, 0,  0, 15, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    tab.push_back(mk(0, 1, 2, 0,  0, 15, 0, 0, 0, 0, 0, 0, 3, 0, 2));

    foreach (tab[i]) begin
      @(posedge clk);
      #1 drive(tab[i].rst, tab[i].v, tab[i].rs, tab[i].rt, tab[i].trs, tab[i].trt,
               tab[i].wa, tab[i].tn, tab[i].md, tab[i].bz, tab[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tab[i].st));
      chk($sformatf("vec%0d_fwd_rs", i), 32'(fwd_rs_sel), 32'(tab[i].frs));
      chk($sformatf("vec%0d_fwd_rt", i), 32'(fwd_rt_sel), 32'(tab[i].frt));
      chk($sformatf("vec%0d_cnt", i), stall_cnt, tab[i].cnt);
    end

    // randomized run against the model, starting from a clean reset
    @(posedge clk);
    #1 drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    q.delete();
    cyc  = 0;
    mcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      logic st_rs, st_rt, m_stall;
      int   f_rs, f_rt;
      @(posedge clk);
      #1 drive(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 4) != 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0) ? 4'(TMAX) : 4'($urandom_range(0, 2)),
               ($urandom_range(0, 7) == 0) ? 4'(TMAX) : 4'($urandom_range(0, 2)),
               5'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0) ? 4'(TMAX) : 4'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 9) == 0));
      while (q.size() > 0 && cyc - q[0].issue > int'(NSTG)) void'(q.pop_front());
      mref(d_rs, d_tuse_rs, st_rs, f_rs);
      mref(d_rt, d_tuse_rt, st_rt, f_rt);
      m_stall = st_rs | st_rt | (d_valid & d_is_md & md_busy);
      @(negedge clk);
      chk("rnd_stall", 32'(stall), 32'(m_stall));
      chk("rnd_fwd_rs", 32'(fwd_rs_sel), 32'(f_rs));
      chk("rnd_fwd_rt", 32'(fwd_rt_sel), 32'(f_rt));
      chk("rnd_cnt", stall_cnt, 32'(mcnt));
      if (reset) begin
        q.delete();
        mcnt = 0;
      end else begin
        if (m_stall && mcnt < 64'hFFFF_FFFF) mcnt++;
        if (d_valid && !m_stall && !flush)
          q.push_back('{wa: d_wa, issue: cyc, tnew: int'(d_tnew)});
      end
      cyc++;
    end

    // counter saturation: preload all-ones, then keep stalling
    @(posedge clk);
    #1 drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 drive(1'b0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    chk("sat_pre_cnt", stall_cnt, 0);
    chk("md_stall", 32'(stall), 1);
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.r_stall_cnt;
    @(negedge clk);
    chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    chk("sat_stay", stall_cnt, 32'hFFFF_FFFF);
    #1 md_busy = 1'b0;
    #1 chk("md_release", 32'(stall), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
